sync_up_counter_tff: RTL and testbench
======================================

# sync_up_counter_tff

Parameterized synchronous up counter built from a chain of T flip-flops. Counts 0 → MODULUS-1 and wraps cleanly to 0 in a single clock edge, with no asynchronous self-reset. Provides terminal-count and cascade-carry outputs so several instances chain into wider counters, and serves as the up-counting companion to the counter family's down counters.

## Interface

Parameters:
- WIDTH, default 3: counter width in bits; minimum 1.
- MODULUS, default 8: count sequence length; legal range 2..2^WIDTH; the count wraps after MODULUS-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low; clock clk.
- en  input  1  count enable; the counter advances by one on each clk edge while high.
- clr  input  1  synchronous clear, active-high.
- q  output  WIDTH  current count.
- tc  output  1  terminal count: high when q == MODULUS-1 (combinational from q).
- co  output  1  cascade carry: tc & en; drives the en of the next stage.
- ovf  output  1  sticky wrap flag.
- load  input  1  synchronous load (only with UPCNT_LOAD_EN).
- d  input  WIDTH  load value (only with UPCNT_LOAD_EN).

## Operation

- Storage: one T flip-flop per bit, each with asynchronous reset to 0.
- Normal toggle: t[0] = en; t[i] = en & q[0] & … & q[i-1].
- Wrap: when en is high and q >= MODULUS-1, the toggle vector equals q, so next q = 0. Values ≥ MODULUS can only be reached by load. Such values also wrap to 0 on the next enabled edge.
- Power-of-two MODULUS (= 2^WIDTH): the wrap path reduces to natural rollover.
- Priority per edge, highest first: rst_n low → clr → load (if compiled) → en → hold.
- clr: q ← 0 and ovf ← 0, regardless of en or load.
- ovf: set on every enabled wrap edge (count or load-overflow wrap); held until clr or reset. A load does not clear ovf.
- tc: decode of q only. co: tc & en. Both are combinational and glitch-free relative to registered q.

## Timing

- Reset: q = 0, ovf = 0, tc = 0, co = 0 (for MODULUS ≥ 2) while rst_n is low. Assertion is asynchronous and takes effect immediately, mid-count included. Deassertion is synchronous to clk; the first count occurs on the first rising edge with rst_n high and en high.
- Latency: q updates one edge after en, clr, or load is sampled. tc follows q in the same cycle.
- Wrap edge: the cycle with q = MODULUS-1 and en = 1 shows tc = 1 and co = 1. On the next edge, q = 0, tc falls, and ovf rises.
- en low: q, ovf, and co = 0 hold. tc still reflects q.
- Simultaneous clr and en at terminal count: clr wins, q = 0, and ovf stays 0.
- Cascade: stage N+1 increments on exactly the edge on which stage N wraps, with no extra latency.

## Configuration

- Macro UPCNT_LOAD_EN.
- Defined: load and d ports exist. On a load edge (clr low, load high), q ← d, ignoring en. On the next enabled edge, d ≥ MODULUS-1 wraps to 0 and sets ovf.
- Undefined: load and d ports are absent, and the counter only counts, clears, or resets.

## Test plan

- Reset and count, WIDTH=3, MODULUS=8: pulse rst_n low, then hold en=1 for 10 edges. Required: q = 0,1,…,7,0,1; tc high only at q=7; ovf=1 from the edge after q=7.
- Non-power-of-two, WIDTH=4, MODULUS=10: en=1 for 12 edges. Required: q = 0..9,0,1; never 10–15; co pulses exactly while q=9 and en=1.
- Enable gating and clr priority: count to 5, drop en for 3 edges → q holds 5. Count to 7, then assert clr and en together → q=0, ovf=0.
- Async reset mid-count: at q=6, drive rst_n low between edges → q=0 immediately without a clock. Release → counting resumes from 0 on the first enabled edge.
- Cascade: two WIDTH=3/MODULUS=8 instances, with co of the first driving en of the second, run 20 edges. Required: combined value {q_hi,q_lo} = 0..19, with q_hi incrementing on the wrap edge of q_lo.
- UPCNT_LOAD_EN, WIDTH=4, MODULUS=10: load d=12 → q=12. Next enabled edge → q=0 and ovf=1. Load d=3 with en=0 → q=3.

Source files
------------

// File: rtl/sync_up_counter_tff.sv
// sync_up_counter_tff: synchronous up counter built from a chain of T flip-flops.
// Counts 0 .. MODULUS-1 and wraps to 0 on one clock edge. tc and co let several
// instances cascade into a wider counter.
//
// Optional feature: define UPCNT_LOAD_EN to add the synchronous load port pair.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset (q and ovf to 0)
//   en     - count enable
//   clr    - synchronous clear of q and ovf; highest synchronous priority
//   load   - synchronous load of d into q (UPCNT_LOAD_EN only)
//   d      - load value (UPCNT_LOAD_EN only)
//   q      - current count
//   tc     - terminal count, q == MODULUS-1 (combinational from q)
//   co     - cascade carry, tc & en; drives en of the next stage
//   ovf    - sticky flag, set on every enabled wrap edge
module sync_up_counter_tff #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
`ifdef UPCNT_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] TermVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] t_chain;
  logic [WIDTH-1:0] t_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             wrap;

  // Ripple-free toggle chain: bit i toggles when en and all lower bits are 1.
  always_comb begin
    t_chain    = '0;
    t_chain[0] = en;
    for (int i = 1; i < int'(WIDTH); i++) begin
      t_chain[i] = t_chain[i-1] & q_q[i-1];
    end
  end

  // Values at or past the terminal count (the latter only reachable by load)
  // wrap to 0; toggling every set bit clears the register in one edge.
  assign wrap = en & (q_q >= TermVal);

  // Toggle vector and sticky flag; later assignments carry higher priority.
  always_comb begin
    t_d   = wrap ? q_q : t_chain;
    ovf_d = ovf_q | wrap;
`ifdef UPCNT_LOAD_EN
    if (load) begin
      t_d   = q_q ^ d;
      ovf_d = ovf_q;
    end
`endif
    if (clr) begin
      t_d   = q_q;
      ovf_d = 1'b0;
    end
  end

  // T flip-flop bank plus the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_q ^ t_d;
      ovf_q <= ovf_d;
    end
  end

  // TermVal is nonzero for MODULUS >= 2, so tc and co are low during reset.
  assign q   = q_q;
  assign ovf = ovf_q;
  assign tc  = (q_q == TermVal);
  assign co  = tc & en;

endmodule

// File: tb/tb_sync_up_counter_tff.sv
module tb_sync_up_counter_tff;

  logic       clk;
  logic       rst_n;
  logic       en_a, clr_a, en_b, clr_b, en_c, clr_c;
  logic [2:0] q_a, q_lo, q_hi;
  logic [3:0] q_b;
  logic       tc_a, co_a, ovf_a;
  logic       tc_b, co_b, ovf_b;
  logic       tc_lo, co_lo, ovf_lo, tc_hi, co_hi, ovf_hi;
`ifdef UPCNT_LOAD_EN
  logic       load_b;
  logic [3:0] d_b;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // Hand-computed sequences after each enabled edge.
  int exp_q_a[10]   = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
  int exp_tc_a[10]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int exp_ovf_a[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  int exp_q_b[12]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_co_b[12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

  sync_up_counter_tff #(.WIDTH(3), .MODULUS(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .clr(clr_a),
`ifdef UPCNT_LOAD_EN
    .load(1'b0), .d(3'd0),
`endif
    .q(q_a), .tc(tc_a), .co(co_a), .ovf(ovf_a)
  );

  sync_up_counter_tff #(.WIDTH(4), .MODULUS(10)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .clr(clr_b),
`ifdef UPCNT_LOAD_EN
    .load(load_b), .d(d_b),
`endif
    .q(q_b), .tc(tc_b), .co(co_b), .ovf(ovf_b)
  );

  sync_up_counter_tff #(.WIDTH(3), .MODULUS(8)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en_c), .clr(clr_c),
`ifdef UPCNT_LOAD_EN
    .load(1'b0), .d(3'd0),
`endif
    .q(q_lo), .tc(tc_lo), .co(co_lo), .ovf(ovf_lo)
  );

  sync_up_counter_tff #(.WIDTH(3), .MODULUS(8)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(co_lo), .clr(clr_c),
`ifdef UPCNT_LOAD_EN
    .load(1'b0), .d(3'd0),
`endif
    .q(q_hi), .tc(tc_hi), .co(co_hi), .ovf(ovf_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b1; clr_a = 1'b0;
    en_b = 1'b0; clr_b = 1'b0;
    en_c = 1'b0; clr_c = 1'b0;
`ifdef UPCNT_LOAD_EN
    load_b = 1'b0; d_b = 4'd0;
`endif
    #1;
    check("rst_q",   32'(q_a), 32'd0);
    check("rst_tc",  32'(tc_a), 32'd0);
    check("rst_co",  32'(co_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    tick();
    check("rst_hold_q", 32'(q_a), 32'd0);
    tick();
    rst_n = 1'b1;

    // Count and wrap, power-of-two modulus.
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("a_q[%0d]", k),   32'(q_a),   32'(exp_q_a[k]));
      check($sformatf("a_tc[%0d]", k),  32'(tc_a),  32'(exp_tc_a[k]));
      check($sformatf("a_ovf[%0d]", k), 32'(ovf_a), 32'(exp_ovf_a[k]));
    end
    en_a = 1'b0;

    // Non-power-of-two modulus; co high only while q=9 with en.
    en_b = 1'b1;
    check("b_co_init", 32'(co_b), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("b_q[%0d]", k),  32'(q_b),  32'(exp_q_b[k]));
      check($sformatf("b_co[%0d]", k), 32'(co_b), 32'(exp_co_b[k]));
    end
    check("b_ovf", 32'(ovf_b), 32'd1);
    en_b = 1'b0;
    #1;
    check("b_co_en_low", 32'(co_b), 32'd0);

    // Clear, enable gating, clr beats en at terminal count.
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("clr_q",   32'(q_a), 32'd0);
    check("clr_ovf", 32'(ovf_a), 32'd0);
    en_a = 1'b1;
    repeat (5) tick();
    check("cnt5_q", 32'(q_a), 32'd5);
    en_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_q[%0d]", k), 32'(q_a), 32'd5);
      check($sformatf("hold_co[%0d]", k), 32'(co_a), 32'd0);
    end
    en_a = 1'b1;
    repeat (2) tick();
    check("tc7_q",  32'(q_a), 32'd7);
    check("tc7_tc", 32'(tc_a), 32'd1);
    check("tc7_co", 32'(co_a), 32'd1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("clr_en_q",   32'(q_a), 32'd0);
    check("clr_en_ovf", 32'(ovf_a), 32'd0);

    // Asynchronous reset mid-count, then resume from 0.
    repeat (6) tick();
    check("pre_arst_q", 32'(q_a), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", 32'(q_a), 32'd0);
    rst_n = 1'b1;
    tick();
    check("resume_q", 32'(q_a), 32'd1);
    en_a = 1'b0;

    // Cascade: two 3-bit stages form a 6-bit count.
    check("casc_init", 32'({q_hi, q_lo}), 32'd0);
    en_c = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      check($sformatf("casc[%0d]", k), 32'({q_hi, q_lo}), 32'(k));
    end
    en_c = 1'b0;

`ifdef UPCNT_LOAD_EN
    // Load out-of-range value, wrap on next enabled edge, load with en low.
    check("ld_pre_ovf", 32'(ovf_b), 32'd0);
    load_b = 1'b1; d_b = 4'd12;
    tick();
    load_b = 1'b0;
    check("ld12_q",   32'(q_b), 32'd12);
    check("ld12_ovf", 32'(ovf_b), 32'd0);
    en_b = 1'b1;
    tick();
    en_b = 1'b0;
    check("ld_wrap_q",   32'(q_b), 32'd0);
    check("ld_wrap_ovf", 32'(ovf_b), 32'd1);
    load_b = 1'b1; d_b = 4'd3;
    tick();
    load_b = 1'b0;
    check("ld3_q",   32'(q_b), 32'd3);
    check("ld3_ovf", 32'(ovf_b), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
